// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default depth for the instruction fetch buffer.
package fetch_pkg;
  localparam int FETCH_DEPTH = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } fetch_slot_t;
  typedef logic [$clog2(FETCH_DEPTH):0] fetch_ptr_t;
endpackage

// File: rtl/inst_fetch_buffer_if.sv
// inst_fetch_buffer_if: req/gnt/rvalid instruction memory bus.
interface inst_fetch_buffer_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_slot_ring.sv
// fetch_slot_ring: in-order slot storage with head/fill/tail pointers and flush.
module fetch_slot_ring
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          alloc_i,
  input  logic [31:0]   alloc_pc_i,
  input  logic          fill_i,
  input  logic          fill_skip_i,
  input  logic [31:0]   fill_inst_i,
  input  logic          pop_i,
  output logic [AW:0]   head_o,
  output logic [AW:0]   fill_o,
  output logic [AW:0]   tail_o,
  output fetch_slot_t   head_slot_o
);
  fetch_slot_t slots_q [DEPTH];
  logic [AW:0] head_q, fill_q, tail_q;
  assign head_o = head_q;
  assign fill_o = fill_q;
  assign tail_o = tail_q;
  assign head_slot_o = slots_q[head_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
    end else if (flush_i) begin
      head_q <= tail_q;
      fill_q <= tail_q;
      for (int i = 0; i < DEPTH; i++) slots_q[i].filled <= 1'b0;
    end else begin
      if (alloc_i) begin
        slots_q[tail_q[AW-1:0]].pc     <= alloc_pc_i;
        slots_q[tail_q[AW-1:0]].filled <= 1'b0;
        tail_q <= tail_q + 1'b1;
      end
      // a bypassed response consumed in the same cycle never lands as filled
      if (fill_i) begin
        slots_q[fill_q[AW-1:0]].inst   <= fill_inst_i;
        slots_q[fill_q[AW-1:0]].filled <= ~fill_skip_i;
        fill_q <= fill_q + 1'b1;
      end
      if (pop_i) head_q <= head_q + 1'b1;
    end
  end
endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: PC issue to imem, in-order response ring, flush/drain; FETCH_BYPASS_EN enables rdata->decode bypass.
module inst_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                pc_i,
  input  logic                       pc_v_i,
  output logic                       stall_i,
  input  logic                       pc_v_x,
  inst_fetch_buffer_if.master        imem,
  output logic                       inst_v_d,
  output logic [31:0]                inst_d,
  output logic [31:0]                pc_d,
  input  logic                       stall_d
);
  logic [AW:0] head, fill, tail, used, pend;
  fetch_slot_t head_slot;
  logic [7:0] drop_q, drop_d;
  logic grant, resp_keep, ring_v, byp, pop;
  assign used = tail - head;
  assign pend = tail - fill;
  assign imem.req = pc_v_i & ~pc_v_x & ~reset & ~used[AW];
  assign imem.addr = pc_i;
  assign grant = imem.req & imem.gnt;
  assign stall_i = pc_v_i & ~grant;
  assign resp_keep = imem.rvalid & ~pc_v_x & (drop_q == '0);
  assign ring_v = head_slot.filled & (head != tail);
`ifdef FETCH_BYPASS_EN
  assign byp = resp_keep & (fill == head) & (head != tail);
  assign inst_d = ring_v ? head_slot.inst : imem.rdata;
`else
  assign byp = 1'b0;
  assign inst_d = head_slot.inst;
`endif
  assign inst_v_d = ~pc_v_x & (ring_v | byp);
  assign pc_d = head_slot.pc;
  assign pop = inst_v_d & ~stall_d;
  // a redirect during drain adds to the responses still owed to stale requests
  always_comb drop_d = pc_v_x ? drop_q + 8'(pend) - 8'(imem.rvalid)
                              : drop_q - 8'(imem.rvalid && drop_q != '0);
  always_ff @(posedge clk) drop_q <= reset ? '0 : drop_d;
  fetch_slot_ring #(.DEPTH(DEPTH)) u_ring (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (pc_v_x),
    .alloc_i     (grant),
    .alloc_pc_i  (pc_i),
    .fill_i      (resp_keep),
    .fill_skip_i (byp & pop),
    .fill_inst_i (imem.rdata),
    .pop_i       (pop),
    .head_o      (head),
    .fill_o      (fill),
    .tail_o      (tail),
    .head_slot_o (head_slot)
  );
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: randomized bench against a queue-based model of fetch ordering and flush.
module tb_inst_fetch_buffer;
  import fetch_pkg::*;
  localparam int D = FETCH_DEPTH;
  logic clk = 1'b0;
  logic reset, pc_v_i, stall_i, pc_v_x, inst_v_d, stall_d;
  logic [31:0] pc_i, inst_d, pc_d;
  inst_fetch_buffer_if imem();
  inst_fetch_buffer #(.DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_i     (pc_i),
    .pc_v_i   (pc_v_i),
    .stall_i  (stall_i),
    .pc_v_x   (pc_v_x),
    .imem     (imem),
    .inst_v_d (inst_v_d),
    .inst_d   (inst_d),
    .pc_d     (pc_d),
    .stall_d  (stall_d)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a3c, a[31:16]} ^ 32'h1357_9bdf;
  endfunction
  typedef struct {logic [31:0] pc; bit arr;} ent_t;
  typedef struct {logic [31:0] pc; int rdy; bit live;} mem_t;
  ent_t exq[$];
  mem_t mq[$];
  logic [31:0] pc;
  int last_rdy;
  initial begin
    bit rv, req_e, v_e, byp, g, pop, stl;
    int phase, lat, rdy;
    mem_t m;
    pc = 0;
    last_rdy = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      phase = (cyc / 400) % 4;
      reset = (cyc < 2) || ($urandom_range(199) == 0);
      pc_v_i = !reset && ($urandom_range(9) != 0);
      pc_v_x = !reset && ($urandom_range(24) == 0);
      pc_i = pc;
      imem.gnt = $urandom_range(9) < 8;
      stall_d = phase == 0 ? 1'b0 : phase == 1 ? ($urandom_range(9) < 3) :
                phase == 2 ? ($urandom_range(9) < 9) : ($urandom_range(1) == 0);
      rv = !reset && mq.size() > 0 && mq[0].rdy <= cyc;
      imem.rvalid = rv;
      imem.rdata = rv ? word(mq[0].pc) : $urandom;
      @(negedge clk);
      req_e = pc_v_i && !pc_v_x && !reset && exq.size() < D;
      check("imem_req", 32'(imem.req), 32'(req_e));
      g = req_e && imem.gnt;
      stl = pc_v_i && !g;
      byp = 1'b0;
      v_e = 1'b0;
      if (!reset) begin
        check("stall_i", 32'(stall_i), 32'(stl));
        check("imem_addr", imem.addr, pc);
`ifdef FETCH_BYPASS_EN
        byp = rv && mq[0].live && exq.size() > 0 && !exq[0].arr;
`endif
        v_e = !pc_v_x && exq.size() > 0 && (exq[0].arr || byp);
        check("inst_v_d", 32'(inst_v_d), 32'(v_e));
        if (v_e) begin
          check("pc_d", pc_d, exq[0].pc);
          check("inst_d", inst_d, word(exq[0].pc));
        end
      end
      pop = v_e && !stall_d;
      if (reset) begin
        exq.delete();
        mq.delete();
        pc = 0;
      end else if (pc_v_x) begin
        exq.delete();
        foreach (mq[i]) mq[i].live = 1'b0;
        if (rv) void'(mq.pop_front());
        pc = {20'h0, 4'($urandom_range(15)), 8'h0} + 32'h100;
      end else begin
        if (rv) begin
          m = mq.pop_front();
          if (m.live)
            for (int i = 0; i < exq.size(); i++)
              if (!exq[i].arr) begin
                exq[i].arr = 1'b1;
                break;
              end
        end
        if (pop) void'(exq.pop_front());
        if (g) begin
          lat = $urandom_range(1, 4);
          rdy = (cyc + lat > last_rdy + 1) ? cyc + lat : last_rdy + 1;
          last_rdy = rdy;
          mq.push_back('{pc: pc, rdy: rdy, live: 1'b1});
          exq.push_back('{pc: pc, arr: 1'b0});
        end
        if (pc_v_i && !stl) pc = pc + 4;
      end
      @(posedge clk);
      #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
